regwrite_queue: RTL and testbench

Write-side producer for the integer register file: merges single-cycle pipeline writeback results with out-of-order results from long-latency units (divider, FP-to-int) onto the register file's single write port (we3/a3/wd3). Long-latency results are held in a small FIFO and drain into idle write-port cycles. A per-register busy scoreboard tells the issue logic which destinations still have a write outstanding.

---
 rtl/regwrite_queue.sv | 71 +++++++
 tb/tb_regwrite_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_queue.sv
// regwrite_queue: merges same-cycle pipeline writebacks and queued long-latency
// results onto the single register-file write port, with a per-register busy scoreboard.
module regwrite_queue #(
  parameter int XLEN        = 64,
  parameter int E_SUPPORTED = 0,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PipeWE,
  input  logic [4:0]             PipeRd,
  input  logic [XLEN-1:0]        PipeResult,
  input  logic                   LongValid,
  output logic                   LongReady,
  input  logic [4:0]             LongRd,
  input  logic [XLEN-1:0]        LongResult,
  input  logic                   IssueLong,
  input  logic [4:0]             IssueRd,
  input  logic [4:0]             Rs1,
  input  logic [4:0]             Rs2,
  output logic                   Rs1Busy,
  output logic                   Rs2Busy,
  output logic                   RegWE,
  output logic [4:0]             RegAddr,
  output logic [XLEN-1:0]        RegData,
  output logic [$clog2(DEPTH):0] Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [31:0]     busy;
  logic            pipe_ok, pop, push;
  function automatic logic legal(input logic [4:0] r);
    return r != 5'd0 && !(E_SUPPORTED != 0 && r[4]);
  endfunction
  assign pipe_ok   = PipeWE && legal(PipeRd);
  assign pop       = !reset && !pipe_ok && Count != '0;
  assign LongReady = Count != CW'(DEPTH);
  // illegal destinations complete the handshake but never occupy an entry
  assign push      = !reset && LongValid && LongReady && legal(LongRd);
  assign Rs1Busy   = legal(Rs1) && busy[Rs1];
  assign Rs2Busy   = legal(Rs2) && busy[Rs2];
  always_comb begin
    RegWE   = !reset && (pipe_ok || pop);
    RegAddr = reset ? '0 : pipe_ok ? PipeRd : pop ? rd_mem[rp] : '0;
    RegData = reset ? '0 : pipe_ok ? PipeResult : pop ? data_mem[rp] : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      Count <= '0;
      busy  <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      Count <= Count + CW'(push) - CW'(pop);
      if (pop) busy[rd_mem[rp]] <= 1'b0;
      // a new issue to the register being drained keeps it busy
      if (IssueLong && legal(IssueRd)) busy[IssueRd] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wp]   <= LongRd;
      data_mem[wp] <= LongResult;
    end
  end
endmodule

// File: tb/tb_regwrite_queue.sv
// tb_regwrite_queue: directed and random stimulus against a queue-based reference
// model, on a 32-register instance (k=0) and an RV32E instance (k=1) sharing inputs.
module tb_regwrite_queue;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;
  logic        clk = 0;
  logic        reset = 1;
  logic        PipeWE = 0, LongValid = 0, IssueLong = 0;
  logic [4:0]  PipeRd = 0, LongRd = 0, IssueRd = 0, Rs1 = 0, Rs2 = 0;
  logic [63:0] PipeResult = 0, LongResult = 0;
  logic [1:0]  ready, we, rs1b, rs2b;
  logic [4:0]  addr [2];
  logic [63:0] data [2];
  logic [2:0]  cnt  [2];
  ent_t        q0[$], q1[$];
  logic [31:0] mb [2];
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  regwrite_queue #(.XLEN(64), .E_SUPPORTED(0), .DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .PipeWE(PipeWE), .PipeRd(PipeRd), .PipeResult(PipeResult),
    .LongValid(LongValid), .LongReady(ready[0]), .LongRd(LongRd), .LongResult(LongResult),
    .IssueLong(IssueLong), .IssueRd(IssueRd), .Rs1(Rs1), .Rs2(Rs2),
    .Rs1Busy(rs1b[0]), .Rs2Busy(rs2b[0]), .RegWE(we[0]), .RegAddr(addr[0]),
    .RegData(data[0]), .Count(cnt[0]));
  regwrite_queue #(.XLEN(64), .E_SUPPORTED(1), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .PipeWE(PipeWE), .PipeRd(PipeRd), .PipeResult(PipeResult),
    .LongValid(LongValid), .LongReady(ready[1]), .LongRd(LongRd), .LongResult(LongResult),
    .IssueLong(IssueLong), .IssueRd(IssueRd), .Rs1(Rs1), .Rs2(Rs2),
    .Rs1Busy(rs1b[1]), .Rs2Busy(rs2b[1]), .RegWE(we[1]), .RegAddr(addr[1]),
    .RegData(data[1]), .Count(cnt[1]));

  function automatic bit legal(int k, logic [4:0] r);
    return r != 0 && !(k == 1 && r[4]);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit pwe, logic [4:0] prd, logic [63:0] pres, bit lv, logic [4:0] lrd,
                       logic [63:0] lres, bit il, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2);
    PipeWE = pwe; PipeRd = prd; PipeResult = pres; LongValid = lv; LongRd = lrd;
    LongResult = lres; IssueLong = il; IssueRd = ird; Rs1 = r1; Rs2 = r2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // settle, then compare every output of both instances with the model
  task automatic settle_check();
    #1;
    for (int k = 0; k < 2; k++) begin
      int   sz = (k == 0) ? q0.size() : q1.size();
      ent_t h = '{rd: 0, d: 0};
      bit   p = PipeWE && legal(k, PipeRd);
      bit   pop;
      if (sz > 0) h = (k == 0) ? q0[0] : q1[0];
      pop = !p && sz > 0;
      chk($sformatf("we%0d", k), 64'(we[k]), 64'(p || pop));
      chk($sformatf("addr%0d", k), 64'(addr[k]), p ? 64'(PipeRd) : pop ? 64'(h.rd) : 64'd0);
      chk($sformatf("data%0d", k), data[k], p ? PipeResult : pop ? h.d : 64'd0);
      chk($sformatf("ready%0d", k), 64'(ready[k]), 64'(sz != 4));
      chk($sformatf("count%0d", k), 64'(cnt[k]), 64'(sz));
      chk($sformatf("rs1busy%0d", k), 64'(rs1b[k]), 64'(legal(k, Rs1) && mb[k][Rs1]));
      chk($sformatf("rs2busy%0d", k), 64'(rs2b[k]), 64'(legal(k, Rs2) && mb[k][Rs2]));
    end
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      int   sz = (k == 0) ? q0.size() : q1.size();
      bit   p = PipeWE && legal(k, PipeRd);
      ent_t e = '{rd: LongRd, d: LongResult};
      if (!p && sz > 0) begin
        if (k == 0) mb[k][q0.pop_front().rd] = 0;
        else mb[k][q1.pop_front().rd] = 0;
      end
      if (LongValid && sz != 4 && legal(k, LongRd)) begin
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      if (IssueLong && legal(k, IssueRd)) mb[k][IssueRd] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); mb[0] = 0; mb[1] = 0;
  endtask

  task automatic reset_checks(string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_count"}, 64'(cnt[k]), 64'd0);
      chk({tag, "_ready"}, 64'(ready[k]), 64'd1);
      chk({tag, "_we"}, 64'(we[k]), 64'd0);
      chk({tag, "_addr"}, 64'(addr[k]), 64'd0);
      chk({tag, "_data"}, data[k], 64'd0);
      chk({tag, "_rs1busy"}, 64'(rs1b[k]), 64'd0);
    end
  endtask

  initial begin
    model_reset();
    // reset holds the write port off even with a legal pipeline write
    drive(1, 7, 64'h55, 0, 0, 0, 0, 0, 5, 0);
    #2;
    reset_checks("por");
    @(posedge clk); #1;
    reset = 0;
    idle();
    cycle();

    // pipeline-only writes
    drive(1, 7, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    settle_check();
    chk("pipe_we", 64'(we[0]), 64'd1);
    chk("pipe_addr", 64'(addr[0]), 64'd7);
    chk("pipe_data", data[0], 64'h1234);
    advance();
    drive(1, 0, 64'h99, 0, 0, 0, 0, 0, 0, 0);
    settle_check();
    chk("pipe_x0_we", 64'(we[0]), 64'd0);
    advance();

    // drain order under pipeline starvation
    drive(1, 1, 64'h11, 1, 3, 64'hA, 1, 3, 3, 4); cycle();
    drive(1, 1, 64'h12, 1, 4, 64'hB, 1, 4, 3, 4); cycle();
    drive(1, 1, 64'h13, 1, 5, 64'hC, 1, 5, 3, 4); cycle();
    chk("drain_count", 64'(cnt[0]), 64'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    settle_check();
    chk("drain1_addr", 64'(addr[0]), 64'd3);
    chk("drain1_busy3", 64'(rs1b[0]), 64'd1);
    advance();
    settle_check();
    chk("drain2_addr", 64'(addr[0]), 64'd4);
    chk("drain2_busy3", 64'(rs1b[0]), 64'd0);
    chk("drain2_busy4", 64'(rs2b[0]), 64'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 4);
    settle_check();
    chk("drain3_addr", 64'(addr[0]), 64'd5);
    chk("drain3_data", data[0], 64'hC);
    chk("drain3_busy4", 64'(rs2b[0]), 64'd0);
    advance();
    settle_check();
    chk("drain_done_busy5", 64'(rs1b[0]), 64'd0);
    chk("drain_done_we", 64'(we[0]), 64'd0);
    advance();

    // full back-pressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 64'(i), 1, 5'(6 + i), 64'(100 + i), 0, 0, 0, 0);
      cycle();
    end
    drive(1, 2, 64'h77, 1, 12, 64'hEE, 0, 0, 0, 0);
    settle_check();
    chk("full_count", 64'(cnt[0]), 64'd4);
    chk("full_ready", 64'(ready[0]), 64'd0);
    advance();
    chk("full_hold_count", 64'(cnt[0]), 64'd4);
    drive(0, 0, 0, 1, 12, 64'hEE, 0, 0, 0, 0);
    settle_check();
    chk("full_pop_addr", 64'(addr[0]), 64'd6);
    advance();
    chk("after_pop_ready", 64'(ready[0]), 64'd1);
    chk("after_pop_count", 64'(cnt[0]), 64'd3);
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // scoreboard: set wins over a same-cycle drain clear
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0); cycle();
    drive(1, 1, 64'h1, 1, 9, 64'h909, 0, 0, 9, 0);
    settle_check();
    chk("sb_busy9", 64'(rs1b[0]), 64'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    settle_check();
    chk("sb_drain9", 64'(addr[0]), 64'd9);
    advance();
    idle(); Rs1 = 9;
    settle_check();
    chk("sb_setwins", 64'(rs1b[0]), 64'd1);
    advance();

    // RV32E instance: upper registers are illegal
    drive(1, 18, 64'h18, 1, 17, 64'h17, 1, 20, 20, 17);
    settle_check();
    chk("e_pipe18_we", 64'(we[1]), 64'd0);
    chk("e_pipe18_we_full", 64'(we[0]), 64'd1);
    advance();
    chk("e_long17_count", 64'(cnt[1]), 64'd0);
    chk("e_long17_count_full", 64'(cnt[0]), 64'd1);
    chk("e_issue20_busy", 64'(rs1b[1]), 64'd0);
    chk("e_issue20_busy_full", 64'(rs1b[0]), 64'd1);
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // reset mid-stream with queued entries and busy[5]
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 64'h0, 1, 5'(4 + i), 64'(200 + i), i == 1, 5, 5, 0);
      cycle();
    end
    drive(1, 7, 64'h3, 0, 0, 0, 0, 0, 5, 0);
    settle_check();
    chk("pre_reset_count", 64'(cnt[0]), 64'd3);
    reset = 1;
    #1;
    reset_checks("mid");
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    idle();
    Rs1 = 5;
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end
    idle();
    for (int i = 0; i < 6; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
